// File: rtl/i2c_bus_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_bus_arbiter
//
// Lets NREQ on-chip I2C masters share one open-drain bus (SCL/SDA pads).
// Requesters take turns in round-robin order. Once a requester owns the bus,
// it keeps it until its transaction is finished. The block watches START and
// STOP on the pads, so it also waits for external masters to finish.
//
// The block sits between the requesters' tristate controls and the IOBUF.
// The pad data outputs are tied low, so a tristate value of 0 pulls the line
// low.
//
// Optional feature (define the macro to enable it):
//   I2C_ARB_TIMEOUT_EN  An owner that holds the bus for TIMEOUT cycles is
//                       forced to release it, and timeout pulses for 1 cycle.
//
// Ports
//   clk            system clock
//   reset_n        synchronous reset, active low
//   req[NREQ]      level request, one bit per requester
//   grant[NREQ]    one-hot grant, all-zero when there is no owner
//   req_scl_t[NREQ], req_sda_t[NREQ]
//                  per-requester tristate controls (1 = release the line)
//   scl_i, sda_i   pad inputs (asynchronous, synchronised here)
//   scl_t, sda_t   pad tristate controls (registered)
//   scl_o, sda_o   pad data outputs, constant 0
//   bus_busy       a START has been seen and its STOP has not
//   timeout        1-cycle pulse on a forced release (0 without the macro)
//
// FSM states
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   ST_IDLE    | no owner; grant when the bus has been free long enough
//   ST_OWNED   | one requester owns the bus; its scl_t/sda_t go to the pads
//   ST_RELEASE | drop the grant and release both lines, then return to idle
// -----------------------------------------------------------------------------
module i2c_bus_arbiter #(
  parameter int NREQ        = 2,
  parameter int FREE_CYCLES = 64,
  parameter int TIMEOUT     = 2**20
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  input  logic [NREQ-1:0] req_scl_t,
  input  logic [NREQ-1:0] req_sda_t,
  input  logic            scl_i,
  input  logic            sda_i,
  output logic            scl_t,
  output logic            sda_t,
  output logic            scl_o,
  output logic            sda_o,
  output logic            bus_busy,
  output logic            timeout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int FW = $clog2(FREE_CYCLES + 1);
  localparam logic [NREQ-1:0] GRANT_ONE = NREQ'(1);
  localparam logic [FW-1:0]   FREE_MAX  = FW'(FREE_CYCLES);

  if (NREQ < 1 || NREQ > 8 || FREE_CYCLES < 1 || TIMEOUT < 1) begin : g_param_check
    $error("i2c_bus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWNED   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic            scl_t_q, scl_t_d;
  logic            sda_t_q, sda_t_d;
  logic            bus_busy_q, bus_busy_d;
  logic            timeout_q, timeout_d;
  logic [FW-1:0]   free_cnt_q, free_cnt_d;

  // Pad synchronisers. sda_s3 is the previous synced SDA and is used for
  // edge detection.
  logic scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d;
  logic sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_s3_q, sda_s3_d;

  logic          start_det;
  logic          stop_det;
  logic          timeout_hit;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] pick_cand;
  logic [IW-1:0] rr_next;
  int            pick_pos;

  assign scl_o    = 1'b0;
  assign sda_o    = 1'b0;
  assign grant    = grant_q;
  assign scl_t    = scl_t_q;
  assign sda_t    = sda_t_q;
  assign bus_busy = bus_busy_q;
  assign timeout  = timeout_q;

  always_comb begin
    scl_s1_d = scl_i;
    scl_s2_d = scl_s1_q;
    sda_s1_d = sda_i;
    sda_s2_d = sda_s1_q;
    sda_s3_d = sda_s2_q;
  end

  // Only one SDA edge can appear per cycle, so START and STOP never overlap.
  assign start_det = scl_s2_q &  sda_s3_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & ~sda_s3_q &  sda_s2_q;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [31:0] own_cnt_q, own_cnt_d;

  assign timeout_hit = (state_q == ST_OWNED) && (own_cnt_q == 32'(TIMEOUT - 1));

  always_comb begin
    own_cnt_d = '0;
    if (state_q == ST_OWNED && !timeout_hit) begin
      own_cnt_d = own_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      own_cnt_q <= '0;
    end else begin
      own_cnt_q <= own_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // A forced release also ends the transaction from this block's point of
  // view. Otherwise a stuck owner would block the idle gate forever.
  always_comb begin
    bus_busy_d = bus_busy_q;
    if (timeout_hit) begin
      bus_busy_d = 1'b0;
    end else if (start_det) begin
      bus_busy_d = 1'b1;
    end else if (stop_det) begin
      bus_busy_d = 1'b0;
    end
  end

  // Counts consecutive cycles of a quiet bus with no owner. Because the
  // counter clears whenever there is an owner, FREE_CYCLES of idle bus always
  // separate two grants.
  always_comb begin
    free_cnt_d = free_cnt_q;
    if (bus_busy_q || !scl_s2_q || !sda_s2_q || state_q != ST_IDLE) begin
      free_cnt_d = '0;
    end else if (free_cnt_q != FREE_MAX) begin
      free_cnt_d = free_cnt_q + 1'b1;
    end
  end

  // Round-robin pick: the first set request at or after rr_q, wrapping to 0.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_pos   = 0;
    pick_cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      pick_pos = int'(rr_q) + i;
      if (pick_pos >= NREQ) begin
        pick_pos = pick_pos - NREQ;
      end
      pick_cand = IW'(pick_pos);
      if (!pick_valid && req[pick_cand]) begin
        pick_valid = 1'b1;
        pick_idx   = pick_cand;
      end
    end
  end

  always_comb begin
    rr_next = pick_idx + 1'b1;
    if (int'(pick_idx) == NREQ - 1) begin
      rr_next = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    scl_t_d   = scl_t_q;
    sda_t_d   = sda_t_q;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        scl_t_d = 1'b1;
        sda_t_d = 1'b1;
        if (free_cnt_q == FREE_MAX && pick_valid) begin
          state_d = ST_OWNED;
          owner_d = pick_idx;
          grant_d = GRANT_ONE << pick_idx;
          rr_d    = rr_next;
        end
      end

      ST_OWNED: begin
        scl_t_d = req_scl_t[owner_q];
        sda_t_d = req_sda_t[owner_q];
        if (timeout_hit) begin
          state_d   = ST_RELEASE;
          grant_d   = '0;
          scl_t_d   = 1'b1;
          sda_t_d   = 1'b1;
          timeout_d = 1'b1;
        end else if (!req[owner_q] && !bus_busy_q) begin
          // A dropped request waits for the matching STOP when a
          // transaction is open.
          state_d = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        grant_d = '0;
        scl_t_d = 1'b1;
        sda_t_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        scl_t_d = 1'b1;
        sda_t_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_q       <= '0;
      scl_t_q    <= 1'b1;
      sda_t_q    <= 1'b1;
      bus_busy_q <= 1'b0;
      timeout_q  <= 1'b0;
      free_cnt_q <= '0;
      scl_s1_q   <= 1'b0;
      scl_s2_q   <= 1'b0;
      sda_s1_q   <= 1'b0;
      sda_s2_q   <= 1'b0;
      sda_s3_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      scl_t_q    <= scl_t_d;
      sda_t_q    <= sda_t_d;
      bus_busy_q <= bus_busy_d;
      timeout_q  <= timeout_d;
      free_cnt_q <= free_cnt_d;
      scl_s1_q   <= scl_s1_d;
      scl_s2_q   <= scl_s2_d;
      sda_s1_q   <= sda_s1_d;
      sda_s2_q   <= sda_s2_d;
      sda_s3_q   <= sda_s3_d;
    end
  end

endmodule
